// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges stall, redirect and memory handshakes into
// per-stage write enables, and runs the reset flush, DMEM timeout and halt.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned DMEM_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_hazard_stall,
    input  logic             i_redirect,
    input  logic             i_imem_ready,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ready,
    input  logic             i_halt_req,
    output logic             o_pc_we,
    output logic             o_pc_sel,
    output logic             o_if_id_we,
    output logic             o_if_id_flush,
    output logic             o_id_ex_we,
    output logic             o_id_ex_bubble,
    output logic             o_ex_mem_we,
    output logic             o_mem_wb_we,
    output logic             o_mem_wb_bubble,
    output logic             o_halted,
    output logic             o_bus_error,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int TW = $clog2(DMEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        DMEM_WAIT,
        HALT
    } state_e;

    state_e           state_q, state_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic [TW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frz;
    logic             run_ev;

    always_comb begin
        state_d         = state_q;
        flush_d         = flush_q;
        wait_d          = wait_q;
        frz             = 1'b0;
        run_ev          = 1'b0;
        o_pc_we         = 1'b0;
        o_pc_sel        = 1'b0;
        o_if_id_we      = 1'b0;
        o_if_id_flush   = 1'b0;
        o_id_ex_we      = 1'b0;
        o_id_ex_bubble  = 1'b0;
        o_ex_mem_we     = 1'b0;
        o_mem_wb_we     = 1'b0;
        o_mem_wb_bubble = 1'b0;
        o_halted        = 1'b0;
        o_bus_error     = 1'b0;
        unique case (state_q)
            INIT: begin
                o_if_id_we      = 1'b1;
                o_if_id_flush   = 1'b1;
                o_id_ex_we      = 1'b1;
                o_id_ex_bubble  = 1'b1;
                o_ex_mem_we     = 1'b1;
                o_mem_wb_we     = 1'b1;
                o_mem_wb_bubble = 1'b1;
                if (flush_q == '0) state_d = RUN;
                else flush_d = flush_q - 1'b1;
            end
            RUN: begin
                if (i_dmem_req && !i_dmem_ready) begin
                    frz     = 1'b1;
                    state_d = DMEM_WAIT;
                    wait_d  = TW'(1);
                end else begin
                    run_ev = 1'b1;
                end
            end
            DMEM_WAIT: begin
                if (!i_dmem_ready) begin
                    frz    = 1'b1;
                    wait_d = wait_q + 1'b1;
                    if (wait_q == TW'(DMEM_TIMEOUT)) begin
                        o_bus_error = 1'b1;
                        state_d     = HALT;
                    end
                end else begin
                    run_ev  = 1'b1;
                    state_d = RUN;
                end
            end
            HALT: o_halted = 1'b1;
            default: state_d = INIT;
        endcase

        if (frz) begin
            o_mem_wb_we     = 1'b1;
            o_mem_wb_bubble = 1'b1;
        end

        // Zero-latency release from DMEM_WAIT shares this priority chain
        if (run_ev) begin
            if (i_halt_req) begin
                o_mem_wb_we     = 1'b1;
                o_mem_wb_bubble = 1'b1;
                state_d         = HALT;
            end else if (i_hazard_stall) begin
                o_id_ex_we     = 1'b1;
                o_id_ex_bubble = 1'b1;
                o_ex_mem_we    = 1'b1;
                o_mem_wb_we    = 1'b1;
            end else if (i_redirect) begin
                o_pc_we       = 1'b1;
                o_pc_sel      = 1'b1;
                o_if_id_we    = 1'b1;
                o_if_id_flush = 1'b1;
                o_id_ex_we    = 1'b1;
                o_ex_mem_we   = 1'b1;
                o_mem_wb_we   = 1'b1;
            end else if (!i_imem_ready) begin
                o_if_id_we    = 1'b1;
                o_if_id_flush = 1'b1;
                o_id_ex_we    = 1'b1;
                o_ex_mem_we   = 1'b1;
                o_mem_wb_we   = 1'b1;
            end else begin
                o_pc_we     = 1'b1;
                o_if_id_we  = 1'b1;
                o_id_ex_we  = 1'b1;
                o_ex_mem_we = 1'b1;
                o_mem_wb_we = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == RUN || state_q == DMEM_WAIT) && !o_pc_we && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            flush_q <= FW'(FLUSH_CYCLES - 1);
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: flush, stalls, redirects,
// DMEM wait/timeout, halt, reset recovery and counter saturation.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    // {pc_we,pc_sel,if_id_we,if_id_flush,id_ex_we,id_ex_bubble,
    //  ex_mem_we,mem_wb_we,mem_wb_bubble,halted,bus_error}
    localparam logic [10:0] INITV = 11'b00_11_11_1_11_0_0;
    localparam logic [10:0] RUNV  = 11'b10_10_10_1_10_0_0;
    localparam logic [10:0] FRZ   = 11'b00_00_00_0_11_0_0;
    localparam logic [10:0] BERR  = 11'b00_00_00_0_11_0_1;
    localparam logic [10:0] HAZ   = 11'b00_00_11_1_10_0_0;
    localparam logic [10:0] RED   = 11'b11_11_10_1_10_0_0;
    localparam logic [10:0] IMW   = 11'b00_11_10_1_10_0_0;
    localparam logic [10:0] HLT   = 11'b00_00_00_0_00_1_0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hazard = 1'b0, redirect = 1'b0, imem_rdy = 1'b1;
    logic dmem_req = 1'b0, dmem_rdy = 1'b0, halt_req = 1'b0;
    logic pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;
    logic ex_mem_we, mem_wb_we, mem_wb_bubble, halted, bus_error;
    logic [CW-1:0] stall_cnt;
    logic [10:0] ctl;
    logic in_wait_q = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .FLUSH_CYCLES(4),
        .DMEM_TIMEOUT(8),
        .CNT_W(CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_hazard_stall (hazard),
        .i_redirect     (redirect),
        .i_imem_ready   (imem_rdy),
        .i_dmem_req     (dmem_req),
        .i_dmem_ready   (dmem_rdy),
        .i_halt_req     (halt_req),
        .o_pc_we        (pc_we),
        .o_pc_sel       (pc_sel),
        .o_if_id_we     (if_id_we),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_we     (id_ex_we),
        .o_id_ex_bubble (id_ex_bubble),
        .o_ex_mem_we    (ex_mem_we),
        .o_mem_wb_we    (mem_wb_we),
        .o_mem_wb_bubble(mem_wb_bubble),
        .o_halted       (halted),
        .o_bus_error    (bus_error),
        .o_stall_cycles (stall_cnt)
    );

    assign ctl = {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_we,
                  id_ex_bubble, ex_mem_we, mem_wb_we, mem_wb_bubble,
                  halted, bus_error};

    // Track DMEM_WAIT from the outside: a frozen cycle with a pending
    // unacknowledged request always lands in the wait state.
    always @(posedge clk)
        in_wait_q <= !reset && ctl == FRZ && dmem_req && !dmem_rdy;

    always @(negedge clk)
        if (in_wait_q && !reset)
            assert (dmem_req) else $error("dmem_req dropped while waiting");

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input string tag, input logic [10:0] exp);
        #3;
        chk(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ctl", 32'(ctl), 32'(INITV));
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
    endtask

    task automatic init4(input string tag);
        for (int i = 0; i < 4; i++) tick(tag, INITV);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // T1: three reset edges, then exactly four flush cycles
        @(posedge clk);
        #1;
        chk("t1_rst_ctl", 32'(ctl), 32'(INITV));
        chk("t1_rst_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        init4("t1_init");
        tick("t1_run", RUNV);
        chk("t1_cnt", 32'(stall_cnt), 32'd0);

        // T2: hazard beats redirect, then redirect alone
        hazard = 1'b1; redirect = 1'b1;
        tick("t2_haz", HAZ);
        hazard = 1'b0;
        tick("t2_red", RED);
        redirect = 1'b0;
        chk("t2_cnt", 32'(stall_cnt), 32'd1);

        // T3: five-cycle data wait, released in the ready cycle
        dmem_req = 1'b1;
        for (int i = 0; i < 5; i++) tick("t3_frz", FRZ);
        dmem_rdy = 1'b1;
        tick("t3_rel", RUNV);
        dmem_req = 1'b0; dmem_rdy = 1'b0;
        chk("t3_cnt", 32'(stall_cnt), 32'd6);

        // T5: redirect wins over a missing instruction word
        imem_rdy = 1'b0; redirect = 1'b1;
        tick("t5_red", RED);
        redirect = 1'b0;
        tick("t5_imem", IMW);
        imem_rdy = 1'b1;
        chk("t5_cnt", 32'(stall_cnt), 32'd7);

        // T4: timeout on the 8th DMEM_WAIT cycle, then halt
        dmem_req = 1'b1;
        for (int i = 0; i < 8; i++) tick("t4_frz", FRZ);
        tick("t4_berr", BERR);
        dmem_req = 1'b0; redirect = 1'b1; halt_req = 1'b1;
        tick("t4_halt", HLT);
        tick("t4_halt2", HLT);
        redirect = 1'b0; halt_req = 1'b0;
        chk("t4_cnt_sat", 32'(stall_cnt), 32'd15);

        // T6: reset from HALT, then a halt request
        rst_cycle();
        init4("t6_init");
        halt_req = 1'b1;
        tick("t6_hreq", FRZ);
        halt_req = 1'b0;
        tick("t6_hlt", HLT);
        chk("t6_hcnt", 32'(stall_cnt), 32'd1);

        // T6: reset in the middle of a data wait
        rst_cycle();
        init4("t6_init2");
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) tick("t6_wfrz", FRZ);
        reset = 1'b1;
        tick("t6_wrst", FRZ);
        reset = 1'b0; dmem_req = 1'b0;
        chk("t6_wrst_cnt", 32'(stall_cnt), 32'd0);
        init4("t6_init3");

        // Release from DMEM_WAIT straight into a hazard stall, then a halt
        dmem_req = 1'b1;
        tick("t7_frz", FRZ);
        tick("t7_frz", FRZ);
        dmem_rdy = 1'b1; hazard = 1'b1;
        tick("t7_haz", HAZ);
        dmem_req = 1'b0; dmem_rdy = 1'b0; hazard = 1'b0;
        tick("t7_run", RUNV);
        chk("t7_cnt", 32'(stall_cnt), 32'd3);
        dmem_req = 1'b1;
        tick("t7_frz2", FRZ);
        dmem_rdy = 1'b1; halt_req = 1'b1;
        tick("t7_hrel", FRZ);
        dmem_req = 1'b0; dmem_rdy = 1'b0; halt_req = 1'b0;
        tick("t7_hlt", HLT);
        chk("t7_cnt2", 32'(stall_cnt), 32'd5);

        // T6: 20 stall cycles saturate a 4-bit counter at 15
        rst_cycle();
        init4("t8_init");
        hazard = 1'b1;
        for (int i = 0; i < 15; i++) tick("t8_haz", HAZ);
        chk("t8_cnt15", 32'(stall_cnt), 32'd15);
        for (int i = 0; i < 5; i++) tick("t8_haz", HAZ);
        chk("t8_sat", 32'(stall_cnt), 32'd15);
        hazard = 1'b0;
        tick("t8_run", RUNV);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
